// File: rtl/fos_inverse_seq_v1.sv
// Inverse first-order-section filter: x[k] = y[k] + a1*y[k-1] + x[k-1].
// One product per sample from an iterative radix-4 Booth multiplier.
module fos_inverse_seq_v1 #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] a1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] x_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MULT, ADD, DONE} state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0]          y_cur;
    logic [WIDTH-1:0]          y_prev;
    logic [WIDTH-1:0]          x_prev;
    logic [WIDTH-1:0]          x_reg;
    logic [WIDTH-1:0]          sum;
    logic [WIDTH:0]            booth_q;
    logic signed [2*WIDTH-1:0] mcand;
    logic signed [2*WIDTH-1:0] acc;
    logic signed [2*WIDTH-1:0] partial;
    logic [3:0]                iter;

    // Booth digit from the low three bits of the shifting multiplier window
    always_comb begin
        partial = '0;
        unique case (booth_q[2:0])
            3'b001, 3'b010: partial = mcand;
            3'b011:         partial = mcand <<< 1;
            3'b100:         partial = -(mcand <<< 1);
            3'b101, 3'b110: partial = -mcand;
            default:        partial = '0;
        endcase
    end

    assign sum = y_cur + acc[FRAC+WIDTH-1:FRAC] + x_prev;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid) state_nx = MULT;
            MULT: if (iter == 4'd15) state_nx = ADD;
            ADD:  state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_cur   <= '0;
            y_prev  <= '0;
            x_prev  <= '0;
            x_reg   <= '0;
            booth_q <= '0;
            mcand   <= '0;
            acc     <= '0;
            iter    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        y_cur   <= y_in;
                        booth_q <= {a1, 1'b0};
                        mcand   <= {{WIDTH{y_prev[WIDTH-1]}}, y_prev};
                        acc     <= '0;
                        iter    <= '0;
                    end
                end
                MULT: begin
                    acc     <= acc + partial;
                    mcand   <= mcand <<< 2;
                    booth_q <= {booth_q[WIDTH], booth_q[WIDTH], booth_q[WIDTH:2]};
                    iter    <= iter + 4'd1;
                end
                ADD: begin
                    x_reg  <= sum;
                    y_prev <= y_cur;
                    x_prev <= sum;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign x_out     = x_reg;

endmodule
